// File: rtl/fixed_point_issue_unit.sv
// -----------------------------------------------------------------------------
// fixed_point_issue_unit
//
// Issues one fixed-point operation at a time to an external fixed-point unit,
// waits for its result (or a timeout), and presents the result on a
// writeback port until the consumer accepts it.
//
// Ports
//   clk            sole clock, rising edge
//   reset          asynchronous reset, active low
//   req_valid/req_ready/req_op/req_rs1/req_rs2/req_rd
//                  issue request handshake and payload (rs2 unused for SQRT)
//   fpu_operand_1/fpu_operand_2/fpu_operation
//                  operands and operation presented to the fixed-point unit
//   fpu_result/fpu_ready
//                  result and result-valid from the fixed-point unit
//   wb_valid/wb_ready/wb_rd/wb_data/wb_error
//                  writeback handshake, destination tag, result, timeout flag
//   busy           high whenever a request is in flight (not IDLE)
// -----------------------------------------------------------------------------
module fixed_point_issue_unit #(
    parameter int WIDTH        = 32,
    parameter int FBITS        = 10,
    parameter int TIMEOUT      = 64,
    parameter int MUL_MIN_LAT  = 6,
    parameter int SQRT_MIN_LAT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_rs1,
    input  logic [WIDTH-1:0] req_rs2,
    input  logic [4:0]       req_rd,
    output logic [WIDTH-1:0] fpu_operand_1,
    output logic [WIDTH-1:0] fpu_operand_2,
    output logic [1:0]       fpu_operation,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_ready,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             wb_error,
    output logic             busy
);

    // Operation encodings shared with the fixed-point unit.
    localparam logic [1:0] FPU_ADD  = 2'd0;
    localparam logic [1:0] FPU_SUB  = 2'd1;
    localparam logic [1:0] FPU_MUL  = 2'd2;
    localparam logic [1:0] FPU_SQRT = 2'd3;

    // The counter never passes TIMEOUT-1: the timeout forces an exit there.
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    // FBITS only documents the operand format; a value wider than the
    // operand itself would be a mis-parameterisation, made visible in the
    // elaborated hierarchy by this named block.
    if (FBITS > WIDTH) begin : g_fbits_exceeds_width
    end

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] rs1_r;
    logic [WIDTH-1:0] rs2_r;
    logic [4:0]       rd_r;
    logic             capture_s;
    logic             timeout_s;

    // Number of EXEC cycles during which fpu_ready is not trusted for an op.
    // ADD and SUB accept the first ready they see.
    function automatic int min_lat_f(input logic [1:0] op);
        case (op)
            FPU_ADD:  min_lat_f = 0;
            FPU_SUB:  min_lat_f = 0;
            FPU_MUL:  min_lat_f = MUL_MIN_LAT;
            FPU_SQRT: min_lat_f = SQRT_MIN_LAT;
            default:  min_lat_f = 0;
        endcase
    endfunction

    // Operands and operation come straight from the holding registers, so
    // they stay stable through EXEC/WB and keep their last value in IDLE.
    assign fpu_operand_1 = rs1_r;
    assign fpu_operand_2 = rs2_r;
    assign fpu_operation = op_r;

    // Capture/timeout decision for the current EXEC cycle; capture wins
    // when both would apply.
    always_comb begin
        capture_s = 1'b0;
        timeout_s = 1'b0;
        if (state_r == S_EXEC) begin
            if (fpu_ready && (int'(cnt_r) >= min_lat_f(op_r))) begin
                capture_s = 1'b1;
            end else if (cnt_r == CNT_LAST) begin
                timeout_s = 1'b1;
            end else begin
                capture_s = 1'b0;
                timeout_s = 1'b0;
            end
        end else begin
            capture_s = 1'b0;
            timeout_s = 1'b0;
        end
    end

    // Issue FSM: holding registers, EXEC cycle counter and registered
    // handshake/writeback outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            op_r      <= FPU_ADD;
            rs1_r     <= {WIDTH{1'b0}};
            rs2_r     <= {WIDTH{1'b0}};
            rd_r      <= 5'd0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            wb_valid  <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= {WIDTH{1'b0}};
            wb_error  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_r      <= req_op;
                        rs1_r     <= req_rs1;
                        rs2_r     <= req_rs2;
                        rd_r      <= req_rd;
                        cnt_r     <= {CNT_W{1'b0}};
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state_r   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (capture_s) begin
                        wb_data  <= fpu_result;
                        wb_rd    <= rd_r;
                        wb_error <= 1'b0;
                        wb_valid <= 1'b1;
                        state_r  <= S_WB;
                    end else if (timeout_s) begin
                        wb_data  <= {WIDTH{1'b0}};
                        wb_rd    <= rd_r;
                        wb_error <= 1'b1;
                        wb_valid <= 1'b1;
                        state_r  <= S_WB;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_WB: begin
                    // req_ready only rises on this edge, so a new request
                    // cannot be taken until the following edge.
                    if (wb_ready) begin
                        wb_valid  <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= S_IDLE;
                    end
                end
                default: begin
                    wb_valid  <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_fixed_point_issue_unit
//
// Scoreboard bench: the driver pushes the expected writeback (tag, data,
// error, latency, consumer back-pressure) when a request is accepted; a
// negedge monitor pops and compares whenever wb_valid is presented. The
// fixed-point unit is a combinational behavioural model whose fpu_ready
// timing is chosen per request.
// -----------------------------------------------------------------------------
module tb_fixed_point_issue_unit;

    localparam int WIDTH        = 32;
    localparam int FBITS        = 10;
    localparam int TIMEOUT      = 64;
    localparam int MUL_MIN_LAT  = 6;
    localparam int SQRT_MIN_LAT = 3;
    localparam int NEVER        = 1000000;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_SQRT = 2'd3;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_rs1;
    logic [WIDTH-1:0] req_rs2;
    logic [4:0]       req_rd;
    logic [WIDTH-1:0] fpu_operand_1;
    logic [WIDTH-1:0] fpu_operand_2;
    logic [1:0]       fpu_operation;
    logic [WIDTH-1:0] fpu_result;
    logic             fpu_ready = 1'b0;
    logic             wb_valid;
    logic             wb_ready = 1'b0;
    logic [4:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic             wb_error;
    logic             busy;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
        int          hold;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   acc_edge = 0;
    int   rdelay = NEVER;
    bit   stale = 1'b0;
    int   last_hs_edge = -1000;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fixed_point_issue_unit #(
        .WIDTH(WIDTH), .FBITS(FBITS), .TIMEOUT(TIMEOUT),
        .MUL_MIN_LAT(MUL_MIN_LAT), .SQRT_MIN_LAT(SQRT_MIN_LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2),
        .fpu_operation(fpu_operation), .fpu_result(fpu_result), .fpu_ready(fpu_ready),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_error(wb_error), .busy(busy)
    );

    // Fixed-point square root: floor(sqrt(a * 2^FBITS)).
    function automatic logic [31:0] isqrt_fx(input logic [31:0] a);
        logic [63:0] v;
        logic [31:0] r;
        logic [31:0] t;
        v = {32'd0, a} << FBITS;
        r = 32'd0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (32'd1 << b);
            if (({32'd0, t} * {32'd0, t}) <= v) r = t;
        end
        return r;
    endfunction

    // Behavioural fixed-point unit (Q.FBITS two's complement).
    function automatic logic [31:0] fpu_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  begin p = (sa * sb) >>> FBITS; return p[31:0]; end
            default: return isqrt_fx(a);
        endcase
    endfunction

    assign fpu_result = fpu_model(fpu_operation, fpu_operand_1, fpu_operand_2);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // fpu_ready: while a request is outstanding it rises rdelay edges after
    // acceptance; otherwise it is noise (or held high to model stale ready).
    always @(negedge clk) begin
        #1;
        if (sb_q.size() != 0) fpu_ready = ((cyc + 1 - acc_edge) >= rdelay);
        else fpu_ready = stale ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // Expected result from the rules: capture at the first edge k>=1 with
    // ready seen and k-1 >= min latency; otherwise timeout at edge TIMEOUT.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int rdl, input int hold, input bit keep);
        int   guard;
        int   minlat;
        exp_t e;
        guard = 0;
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
        while (!req_ready && guard < 400) begin @(negedge clk); guard++; end
        if (!req_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: req_ready still 0 after %0d cycles, expected 1", guard);
            req_valid = 1'b0;
            return;
        end
        check("accept_after_handshake", 64'((cyc + 1) > last_hs_edge), 64'd1);
        minlat = (op == OP_MUL) ? MUL_MIN_LAT : (op == OP_SQRT) ? SQRT_MIN_LAT : 0;
        e.lat = -1;
        for (int k = 1; k <= TIMEOUT; k++) begin
            if (k >= rdl && (k - 1) >= minlat) begin e.lat = k; break; end
        end
        e.rd = rd; e.acc = cyc + 1; e.hold = hold;
        if (e.lat < 0) begin e.lat = TIMEOUT; e.err = 1'b1; e.data = 32'd0; end
        else begin e.err = 1'b0; e.data = fpu_model(op, a, b); end
        acc_edge = cyc + 1; rdelay = rdl; stale = (rdl == 0);
        sb_q.push_back(e);
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb_q.size() != 0 || busy || wb_valid) && guard < 300) begin @(negedge clk); guard++; end
        check("drain_idle", 64'(guard < 300), 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
        check({tag, "_wb_error"}, 64'(wb_error), 64'd0);
        check({tag, "_wb_data"},  64'(wb_data), 64'd0);
        check({tag, "_wb_rd"},    64'(wb_rd), 64'd0);
        check({tag, "_busy"},     64'(busy), 64'd0);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_fpu_op"},   64'(fpu_operation), 64'(OP_ADD));
        check({tag, "_fpu_opnd1"}, 64'(fpu_operand_1), 64'd0);
        check({tag, "_fpu_opnd2"}, 64'(fpu_operand_2), 64'd0);
    endtask

    // Monitor / writeback consumer.
    bit          seen = 1'b0;
    bit          expect_idle = 1'b0;
    int          hold_left = 0;
    logic [4:0]  p_rd;
    logic [31:0] p_data;
    logic        p_err;
    exp_t        m_e;

    always @(negedge clk) begin
        if (!reset) begin
            seen = 1'b0; expect_idle = 1'b0; hold_left = 0; wb_ready = 1'b0;
        end else begin
            if (expect_idle) begin
                check("idle_after_hs_req_ready", 64'(req_ready), 64'd1);
                check("idle_after_hs_busy", 64'(busy), 64'd0);
                check("idle_after_hs_wb_valid", 64'(wb_valid), 64'd0);
                expect_idle = 1'b0;
            end
            if (wb_valid) begin
                if (!seen) begin
                    if (sb_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_wb: wb_valid=1 rd=%0d, expected no writeback", wb_rd);
                        hold_left = 0;
                    end else begin
                        m_e = sb_q.pop_front();
                        check("wb_rd", 64'(wb_rd), 64'(m_e.rd));
                        check("wb_data", 64'(wb_data), 64'(m_e.data));
                        check("wb_error", 64'(wb_error), 64'(m_e.err));
                        check("wb_latency", 64'(cyc - m_e.acc), 64'(m_e.lat));
                        hold_left = m_e.hold;
                    end
                    seen = 1'b1;
                    p_rd = wb_rd; p_data = wb_data; p_err = wb_error;
                end else begin
                    check("hold_wb_data", 64'(wb_data), 64'(p_data));
                    check("hold_wb_rd", 64'(wb_rd), 64'(p_rd));
                    check("hold_wb_error", 64'(wb_error), 64'(p_err));
                    check("hold_req_ready", 64'(req_ready), 64'd0);
                    check("hold_busy", 64'(busy), 64'd1);
                end
                if (hold_left == 0) begin
                    wb_ready = 1'b1; seen = 1'b0; expect_idle = 1'b1; last_hs_edge = cyc + 1;
                end else begin
                    wb_ready = 1'b0; hold_left--;
                end
            end else begin
                wb_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  op;
        int          rdl;
        reset = 1'b0; req_valid = 1'b0; req_op = 2'd0;
        req_rs1 = 32'd0; req_rs2 = 32'd0; req_rd = 5'd0;
        repeat (3) @(negedge clk);
        check_reset_values("in_reset");
        #2 reset = 1'b1;
        @(negedge clk);
        check("post_reset_req_ready", 64'(req_ready), 64'd1);

        // 3.0 + 2.0, result ready immediately.
        issue(OP_ADD, 32'h0000_0C00, 32'h0000_0800, 5'd3, 1, 0, 1'b0);
        drain();
        // 3.0 * 2.0 with fpu_ready stuck high from before the request.
        stale = 1'b1;
        repeat (2) @(negedge clk);
        issue(OP_MUL, 32'h0000_0C00, 32'h0000_0800, 5'd5, 0, 0, 1'b0);
        drain();
        // SQRT that never completes, consumer stalls 10 cycles.
        stale = 1'b0;
        issue(OP_SQRT, 32'h0001_0000, 32'hDEAD_BEEF, 5'd9, NEVER, 10, 1'b0);
        drain();
        check("sqrt_timeout_last_hs", 64'(last_hs_edge > 0), 64'd1);

        // Reset during EXEC of a MUL at cnt=3.
        issue(OP_MUL, 32'h0000_1000, 32'h0000_0C00, 5'd7, 1, 0, 1'b0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        sb_q.delete();
        #1 check_reset_values("mid_exec_reset");
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        issue(OP_ADD, 32'h0000_0400, 32'h0000_0400, 5'd11, 1, 0, 1'b0);
        drain();

        // Back-to-back randomized requests, req_valid held high.
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            rdl = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 10);
            issue(op, $urandom, $urandom, 5'($urandom_range(0, 31)), rdl,
                  $urandom_range(0, 3), (i != 39));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
